// File: rtl/forward_kinematics.sv
// Sequential forward kinematics for the two-link SCARA arm: one shared multiplier,
// one product per state, quarter-wave Q1.15 sine table.
module forward_kinematics #(
    parameter int XW = 64,
    parameter int YW = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    th1,
    input  logic [7:0]    th2,
    input  logic [13:0]   l1,
    input  logic [13:0]   l2,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          data_ready
);
    localparam int AW = 18;
    localparam logic signed [AW-1:0] Y_MAX = AW'(2 ** (YW - 1) - 1);
    localparam logic signed [AW-1:0] Y_MIN = AW'(-(2 ** (YW - 1)));

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

    state_t               state_q, state_d;
    logic [7:0]           th1_q, th1_d, th2_q, th2_d;
    logic [13:0]          l1_q, l1_d, l2_q, l2_d;
    logic signed [AW-1:0] accx_q, accx_d, accy_q, accy_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic                 data_ready_q, data_ready_d;

    logic [8:0]           ang1_raw, ang12_raw, ang1_n, ang12_n, ang_sel, ang_c;
    logic                 use_sum, use_cos, trig_neg;
    logic [6:0]           idx;
    logic [15:0]          t_mag;
    logic signed [16:0]   trig;
    logic [13:0]          l_sel;
    logic signed [31:0]   prod;
    logic signed [16:0]   term;
    logic signed [AW-1:0] acc_sum;
    logic [YW-1:0]        y_sat;

    // Angle reduction, operand select and the single shared product.
    // Negative 9-bit angles wrap correctly modulo 512 when 360 is added.
    always_comb begin
        ang1_raw  = {th1_q[7], th1_q};
        ang12_raw = {th1_q[7], th1_q} + {th2_q[7], th2_q};
        ang1_n    = ang1_raw[8] ? ang1_raw + 9'd360 : ang1_raw;
        ang12_n   = ang12_raw[8] ? ang12_raw + 9'd360 : ang12_raw;
        use_sum   = (state_q == P2) || (state_q == P3);
        use_cos   = (state_q == P0) || (state_q == P2);
        ang_sel   = use_sum ? ang12_n : ang1_n;
        ang_c     = ang_sel;
        if (use_cos)
            ang_c = (ang_sel >= 9'd270) ? ang_sel - 9'd270 : ang_sel + 9'd90;

        if (ang_c <= 9'd90) begin
            idx = 7'(ang_c);
            trig_neg = 1'b0;
        end else if (ang_c <= 9'd180) begin
            idx = 7'(9'd180 - ang_c);
            trig_neg = 1'b0;
        end else if (ang_c <= 9'd270) begin
            idx = 7'(ang_c - 9'd180);
            trig_neg = 1'b1;
        end else begin
            idx = 7'(9'd360 - ang_c);
            trig_neg = 1'b1;
        end

        trig    = trig_neg ? -$signed({1'b0, t_mag}) : $signed({1'b0, t_mag});
        l_sel   = use_sum ? l2_q : l1_q;
        prod    = 32'($signed({1'b0, l_sel})) * 32'(trig);
        term    = 17'(prod >>> 15);
        acc_sum = (use_cos ? accx_q : accy_q) + AW'(term);

        if (acc_sum > Y_MAX)
            y_sat = YW'(Y_MAX);
        else if (acc_sum < Y_MIN)
            y_sat = YW'(Y_MIN);
        else
            y_sat = acc_sum[YW-1:0];
    end

    // round(sin(k deg) * 32767), k = 0..90
    always_comb begin
        case (idx)
            7'd0:  t_mag = 16'd0;     7'd1:  t_mag = 16'd572;   7'd2:  t_mag = 16'd1144;  7'd3:  t_mag = 16'd1715;
            7'd4:  t_mag = 16'd2286;  7'd5:  t_mag = 16'd2856;  7'd6:  t_mag = 16'd3425;  7'd7:  t_mag = 16'd3993;
            7'd8:  t_mag = 16'd4560;  7'd9:  t_mag = 16'd5126;  7'd10: t_mag = 16'd5690;  7'd11: t_mag = 16'd6252;
            7'd12: t_mag = 16'd6813;  7'd13: t_mag = 16'd7371;  7'd14: t_mag = 16'd7927;  7'd15: t_mag = 16'd8481;
            7'd16: t_mag = 16'd9032;  7'd17: t_mag = 16'd9580;  7'd18: t_mag = 16'd10126; 7'd19: t_mag = 16'd10668;
            7'd20: t_mag = 16'd11207; 7'd21: t_mag = 16'd11743; 7'd22: t_mag = 16'd12275; 7'd23: t_mag = 16'd12803;
            7'd24: t_mag = 16'd13328; 7'd25: t_mag = 16'd13848; 7'd26: t_mag = 16'd14364; 7'd27: t_mag = 16'd14876;
            7'd28: t_mag = 16'd15383; 7'd29: t_mag = 16'd15886; 7'd30: t_mag = 16'd16384; 7'd31: t_mag = 16'd16876;
            7'd32: t_mag = 16'd17364; 7'd33: t_mag = 16'd17846; 7'd34: t_mag = 16'd18323; 7'd35: t_mag = 16'd18794;
            7'd36: t_mag = 16'd19260; 7'd37: t_mag = 16'd19720; 7'd38: t_mag = 16'd20173; 7'd39: t_mag = 16'd20621;
            7'd40: t_mag = 16'd21062; 7'd41: t_mag = 16'd21497; 7'd42: t_mag = 16'd21925; 7'd43: t_mag = 16'd22347;
            7'd44: t_mag = 16'd22762; 7'd45: t_mag = 16'd23170; 7'd46: t_mag = 16'd23571; 7'd47: t_mag = 16'd23964;
            7'd48: t_mag = 16'd24351; 7'd49: t_mag = 16'd24730; 7'd50: t_mag = 16'd25101; 7'd51: t_mag = 16'd25465;
            7'd52: t_mag = 16'd25821; 7'd53: t_mag = 16'd26169; 7'd54: t_mag = 16'd26509; 7'd55: t_mag = 16'd26841;
            7'd56: t_mag = 16'd27165; 7'd57: t_mag = 16'd27481; 7'd58: t_mag = 16'd27788; 7'd59: t_mag = 16'd28087;
            7'd60: t_mag = 16'd28377; 7'd61: t_mag = 16'd28659; 7'd62: t_mag = 16'd28932; 7'd63: t_mag = 16'd29196;
            7'd64: t_mag = 16'd29451; 7'd65: t_mag = 16'd29697; 7'd66: t_mag = 16'd29934; 7'd67: t_mag = 16'd30162;
            7'd68: t_mag = 16'd30381; 7'd69: t_mag = 16'd30591; 7'd70: t_mag = 16'd30791; 7'd71: t_mag = 16'd30982;
            7'd72: t_mag = 16'd31163; 7'd73: t_mag = 16'd31335; 7'd74: t_mag = 16'd31498; 7'd75: t_mag = 16'd31650;
            7'd76: t_mag = 16'd31794; 7'd77: t_mag = 16'd31927; 7'd78: t_mag = 16'd32051; 7'd79: t_mag = 16'd32165;
            7'd80: t_mag = 16'd32269; 7'd81: t_mag = 16'd32364; 7'd82: t_mag = 16'd32448; 7'd83: t_mag = 16'd32523;
            7'd84: t_mag = 16'd32587; 7'd85: t_mag = 16'd32642; 7'd86: t_mag = 16'd32687; 7'd87: t_mag = 16'd32722;
            7'd88: t_mag = 16'd32747; 7'd89: t_mag = 16'd32762; 7'd90: t_mag = 16'd32767;
            default: t_mag = 16'd0;
        endcase
    end

    // Sequencer: cos terms land in accx (P0, P2), sin terms in accy (P1, P3).
    always_comb begin
        state_d      = state_q;
        th1_d        = th1_q;
        th2_d        = th2_q;
        l1_d         = l1_q;
        l2_d         = l2_q;
        accx_d       = accx_q;
        accy_d       = accy_q;
        x_d          = x_q;
        y_d          = y_q;
        data_ready_d = data_ready_q;
        case (state_q)
            IDLE: if (enable) begin
                th1_d   = th1;
                th2_d   = th2;
                l1_d    = l1;
                l2_d    = l2;
                accx_d  = '0;
                accy_d  = '0;
                state_d = P0;
            end
            P0: if (!enable) state_d = IDLE;
                else begin accx_d = acc_sum; state_d = P1; end
            P1: if (!enable) state_d = IDLE;
                else begin accy_d = acc_sum; state_d = P2; end
            P2: if (!enable) state_d = IDLE;
                else begin accx_d = acc_sum; state_d = P3; end
            P3: if (!enable) state_d = IDLE;
                else begin
                    accy_d       = acc_sum;
                    x_d          = XW'(accx_q);
                    y_d          = y_sat;
                    data_ready_d = 1'b1;
                    state_d      = DONE;
                end
            DONE: if (!enable) begin
                data_ready_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            th1_q        <= '0;
            th2_q        <= '0;
            l1_q         <= '0;
            l2_q         <= '0;
            accx_q       <= '0;
            accy_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            th1_q        <= th1_d;
            th2_q        <= th2_d;
            l1_q         <= l1_d;
            l2_q         <= l2_d;
            accx_q       <= accx_d;
            accy_q       <= accy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign data_ready = data_ready_q;
endmodule

// File: tb/tb_forward_kinematics.sv
// Scoreboard bench for forward_kinematics: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every data_ready rise.
module tb_forward_kinematics;
    localparam int XW = 64;
    localparam int YW = 14;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic [7:0]    th1, th2;
    logic [13:0]   l1, l2;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          data_ready;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } res_t;

    res_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [XW-1:0] last_x = '0;
    logic [YW-1:0] last_y = '0;
    logic          dr_prev = 1'b0;

    always #5 clk = ~clk;

    forward_kinematics #(.XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .th1(th1), .th2(th2), .l1(l1), .l2(l2),
        .x(x), .y(y), .data_ready(data_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one request, queue its expected result and wait (bounded) for data_ready.
    // With mess set, the inputs are scrambled while the engine is in P1.
    task automatic issue(input int t1, input int t2, input int a, input int b,
                         input logic signed [63:0] ex, input int ey, input bit mess);
        int   n = 0;
        res_t e;
        th1 = 8'(t1); th2 = 8'(t2); l1 = 14'(a); l2 = 14'(b); enable = 1'b1;
        e.x = ex;
        e.y = YW'(ey);
        exp_q.push_back(e);
        last_x = e.x;
        last_y = e.y;
        do begin
            step(1);
            n++;
            if (mess && n == 2) begin
                th1 = 8'd45; th2 = 8'hE2; l1 = 14'd100; l2 = 14'd16383;
            end
        end while (!data_ready && n < 12);
        // data_ready appears on the fifth edge counting the capture edge
        check("latency", 64'(n), 64'd5);
    endtask

    task automatic release_en();
        enable = 1'b0;
        step(1);
        check("drop_ready", 64'(data_ready), 64'd0);
        check("drop_x", x, last_x);
        check("drop_y", 64'(y), 64'(last_y));
    endtask

    always @(negedge clk) begin
        res_t e;
        if (data_ready && !dr_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(data_ready), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result_x", x, e.x);
                check("result_y", 64'(y), 64'(e.y));
            end
        end
        dr_prev = data_ready;
    end

    initial begin
        reset = 1'b0; enable = 1'b1;
        th1 = 8'd0; th2 = 8'd0; l1 = 14'd8936; l2 = 14'd7447;
        step(2);
        check("rst_x", x, 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_ready", 64'(data_ready), 64'd0);
        reset = 1'b1;

        issue(0, 0, 8936, 7447, 16381, 0, 1'b0);        release_en();
        issue(0, 90, 1000, 1000, 999, 999, 1'b0);       release_en();
        issue(-90, 0, 1000, 1000, 0, -2000, 1'b0);      release_en();
        issue(90, 0, 8936, 7447, 0, 8191, 1'b0);        release_en();
        issue(90, -90, 8936, 7447, 7446, 8191, 1'b0);   release_en();
        issue(-90, 0, 8936, 7447, 0, -8192, 1'b0);      release_en();
        issue(-128, -128, 1000, 1000, -858, 182, 1'b0); release_en();

        // inputs change mid-computation, then a long hold in DONE
        issue(0, 0, 8936, 7447, 16381, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("hold_ready", 64'(data_ready), 64'd1);
            check("hold_x", x, last_x);
            check("hold_y", 64'(y), 64'(last_y));
        end
        release_en();

        // abort in P2: no result, outputs retained
        th1 = 8'd30; th2 = 8'd30; l1 = 14'd5000; l2 = 14'd5000; enable = 1'b1;
        step(3);
        enable = 1'b0;
        step(4);
        check("abort_ready", 64'(data_ready), 64'd0);
        check("abort_x", x, last_x);
        check("abort_y", 64'(y), 64'(last_y));

        // reset in P1, then a clean restart
        th1 = 8'd45; th2 = 8'd45; l1 = 14'd3000; l2 = 14'd3000; enable = 1'b1;
        step(2);
        reset = 1'b0; enable = 1'b0;
        step(1);
        check("rst_p1_x", x, 64'd0);
        check("rst_p1_y", 64'(y), 64'd0);
        check("rst_p1_ready", 64'(data_ready), 64'd0);
        reset = 1'b1;
        step(1);
        issue(0, 90, 1000, 1000, 999, 999, 1'b0);       release_en();

        step(2);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
